// File: rtl/difftest_step_pkg.sv
// Shared types and constants for the difftest step controller.
// Optional build macro (used by difftest_step_ctrl): DIFFTEST_STEP_TIMEOUT_EN.
package difftest_step_pkg;

  // Why the controller stopped; the value is latched once and held until reset.
  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_FAIL       = 3'd1,
    CAUSE_CHECKPOINT = 3'd2,
    CAUSE_OVERFLOW   = 3'd3,
    CAUSE_TIMEOUT    = 3'd4,
    CAUSE_MAX_CYCLES = 3'd5
  } done_cause_e;

  // Controller state machine encoding.
  typedef enum logic [2:0] {
    RESET_S = 3'd0,
    INIT    = 3'd1,
    ARB     = 3'd2,
    REQ     = 3'd3,
    WAIT    = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Verdict value meaning "checkpoint reached" rather than a mismatch.
  localparam logic [31:0] TRAP_CHECKPOINT = 32'hff;

  // Width of a core index; at least one bit even for a single core.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/difftest_rr_arb.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or
// after rr_ptr, wrapping around the core count.
module difftest_rr_arb
  import difftest_step_pkg::*;
#(
  parameter  int NUM_CORES = 1,
  localparam int IDX_W     = idx_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx
);

  // Scan from the pointer and take the first requester found.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      int cand;
      cand = (int'(rr_ptr) + k) % NUM_CORES;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/difftest_step_ctrl.sv
// Multi-core difftest step bookkeeping: accumulates committed steps per core,
// issues batched step-check requests to a reference checker (valid/ready),
// waits for each verdict and enforces cycle / checkpoint termination.
// Optional build macro: DIFFTEST_STEP_TIMEOUT_EN enables the no-progress watchdog.
//
// Handshake: req_valid is held with req_core/req_steps stable until a cycle in
// which req_ready is also high; that edge is the transfer. rsp_valid is a
// single-cycle strobe that is only observed while waiting for a verdict.
module difftest_step_ctrl
  import difftest_step_pkg::*;
#(
  parameter  int NUM_CORES      = 1,
  parameter  int STEP_WIDTH     = 8,
  parameter  int ACC_WIDTH      = 16,
  parameter  int TIMEOUT_CYCLES = 5000,
  localparam int IDX_W          = idx_width(NUM_CORES)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CORES*STEP_WIDTH-1:0] step_in,
  input  logic [63:0]                     max_cycles,
  input  logic [63:0]                     max_instrs,
  output logic                            init_valid,
  output logic                            req_valid,
  input  logic                            req_ready,
  output logic [IDX_W-1:0]                req_core,
  output logic [ACC_WIDTH-1:0]            req_steps,
  input  logic                            rsp_valid,
  input  logic [31:0]                     rsp_trap,
  output logic                            done,
  output logic [2:0]                      done_cause,
  output logic [63:0]                     n_cycles,
  output logic [63:0]                     n_instrs,
  output state_e                          state_dbg
);

  localparam int SUM_W = ACC_WIDTH + 1;

  state_e                 state, state_nx;
  done_cause_e            cause_q, cause_nx, term;
  logic [STEP_WIDTH-1:0]  step_d [NUM_CORES];
  logic [ACC_WIDTH-1:0]   acc    [NUM_CORES];
  logic [ACC_WIDTH-1:0]   acc_nx [NUM_CORES];
  logic [NUM_CORES-1:0]   ovf, acc_nz, step_nz;
  logic [IDX_W-1:0]       rr_ptr, core_q, grant_idx;
  logic [ACC_WIDTH-1:0]   steps_q;
  logic [63:0]            n_cycles_q, n_instrs_q;
  logic                   grant_valid, hs, active, any_ovf, cyc_hit, wd_hit;
  logic                   rsp_bad, rsp_ckpt;

  assign active  = (state == INIT) || (state == ARB) || (state == REQ) || (state == WAIT);
  assign hs      = (state == REQ) && req_ready;
  assign any_ovf = active && (|ovf);
  assign cyc_hit = (|max_cycles) && (n_cycles_q >= max_cycles);

  // A non-zero verdict is a checkpoint only when checkpointing is enabled.
  assign rsp_bad  = (state == WAIT) && rsp_valid && (rsp_trap != 32'd0);
  assign rsp_ckpt = rsp_bad && (rsp_trap == TRAP_CHECKPOINT) && (|max_instrs);

  // Per-core next accumulator: add the registered step and, on the handshake
  // for this core, remove the steps just handed to the checker. The extra
  // carry bit detects saturation.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_lane
    logic [SUM_W-1:0] sum;

    // Same-cycle add and subtract so no step is lost at a handshake.
    always_comb begin
      sum = {1'b0, acc[g]} + SUM_W'(step_d[g]);
      if (hs && (core_q == IDX_W'(g))) begin
        sum = sum - {1'b0, steps_q};
      end
    end

    assign ovf[g]     = sum[ACC_WIDTH];
    assign acc_nx[g]  = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    assign acc_nz[g]  = |acc[g];
    assign step_nz[g] = |step_d[g];

    // Register the raw step input one cycle before it is accumulated.
    always_ff @(posedge clock) begin
      if (reset) step_d[g] <= '0;
      else       step_d[g] <= step_in[g*STEP_WIDTH +: STEP_WIDTH];
    end
  end

  difftest_rr_arb #(.NUM_CORES(NUM_CORES)) u_arb (
    .req         (acc_nz),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef DIFFTEST_STEP_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        wd_state;

  assign wd_state = (state == ARB) || (state == REQ) || (state == WAIT);
  assign wd_hit   = wd_state && (wd_cnt >= 32'(TIMEOUT_CYCLES));

  // Count consecutive cycles without any committed step while checking.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (wd_state) begin
      wd_cnt <= (|step_nz) ? 32'd0 : wd_cnt + 32'd1;
    end
  end
`else
  // Watchdog compiled out: never fires (the comparison keeps the limit
  // parameter referenced in this build).
  assign wd_hit = (TIMEOUT_CYCLES < 0) && (|step_nz);
`endif

  // Next-state and termination cause, highest-priority cause first.
  always_comb begin
    state_nx = state;
    cause_nx = cause_q;
    term     = CAUSE_NONE;
    if (rsp_bad && !rsp_ckpt)  term = CAUSE_FAIL;
    else if (rsp_ckpt)         term = CAUSE_CHECKPOINT;
    else if (any_ovf)          term = CAUSE_OVERFLOW;
    else if (wd_hit)           term = CAUSE_TIMEOUT;
    else if (active && cyc_hit) term = CAUSE_MAX_CYCLES;

    case (state)
      RESET_S: state_nx = INIT;
      INIT:    state_nx = ARB;
      ARB:     if (grant_valid) state_nx = REQ;
      REQ:     if (req_ready) state_nx = WAIT;
      WAIT:    if (rsp_valid && (rsp_trap == 32'd0)) state_nx = ARB;
      DONE:    state_nx = DONE;
      default: state_nx = RESET_S;
    endcase

    if (term != CAUSE_NONE) begin
      state_nx = DONE;
      cause_nx = term;
    end
  end

  // Accumulators advance in every working state and freeze in DONE.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (reset)       acc[i] <= '0;
      else if (active) acc[i] <= acc_nx[i];
    end
  end

  // State, request latch, round-robin pointer and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RESET_S;
      cause_q    <= CAUSE_NONE;
      rr_ptr     <= '0;
      core_q     <= '0;
      steps_q    <= '0;
      n_cycles_q <= '0;
      n_instrs_q <= '0;
    end else begin
      state   <= state_nx;
      cause_q <= cause_nx;
      if ((state == ARB) && (state_nx == REQ)) begin
        core_q  <= grant_idx;
        steps_q <= acc[grant_idx];
        rr_ptr  <= (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (hs) begin
        n_instrs_q <= n_instrs_q + 64'(steps_q);
      end
      if (active && (state_nx != DONE)) begin
        n_cycles_q <= n_cycles_q + 64'd1;
      end
    end
  end

  assign init_valid = (state == INIT);
  assign req_valid  = (state == REQ);
  assign req_core   = core_q;
  assign req_steps  = steps_q;
  assign done       = (state == DONE);
  assign done_cause = cause_q;
  assign n_cycles   = n_cycles_q;
  assign n_instrs   = n_instrs_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_difftest_step_ctrl.sv
// Self-checking bench for difftest_step_ctrl (4 cores, randomised stimulus,
// reference model tracking injected and accepted steps per core).
module tb_difftest_step_ctrl;
  import difftest_step_pkg::*;

  localparam int NC = 4;
  localparam int SW = 8;
  localparam int AW = 16;
  localparam int TO = 20;

  // ---------------- clock / reset / DUT ----------------
  logic             clock = 1'b0;
  logic             reset;
  logic [NC*SW-1:0] step_in;
  logic [63:0]      max_cycles, max_instrs;
  logic             init_valid, req_valid, req_ready, rsp_valid, done;
  logic [1:0]       req_core;
  logic [AW-1:0]    req_steps;
  logic [31:0]      rsp_trap;
  logic [2:0]       done_cause;
  logic [63:0]      n_cycles, n_instrs;
  state_e           state_dbg;

  always #5 clock = ~clock;

  difftest_step_ctrl #(
    .NUM_CORES(NC), .STEP_WIDTH(SW), .ACC_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .step_in(step_in),
    .max_cycles(max_cycles), .max_instrs(max_instrs),
    .init_valid(init_valid), .req_valid(req_valid), .req_ready(req_ready),
    .req_core(req_core), .req_steps(req_steps),
    .rsp_valid(rsp_valid), .rsp_trap(rsp_trap),
    .done(done), .done_cause(done_cause),
    .n_cycles(n_cycles), .n_instrs(n_instrs), .state_dbg(state_dbg)
  );

  // ---------------- model / scoreboard ----------------
  int              n_tests = 0;
  int              n_fail  = 0;
  longint unsigned inj     [NC];
  longint unsigned acc_tot [NC];
  longint unsigned ticks;
  logic [1:0]      exp_q [$];
  logic [1:0]      seen_q[$];
  bit              auto_rsp, awaiting, rand_ready;
  int              rsp_delay, rsp_wait;
  logic [31:0]     trap_cfg;

  function automatic longint unsigned inj_sum();
    longint unsigned s = 0;
    for (int i = 0; i < NC; i++) s += inj[i];
    return s;
  endfunction

  // One clock: account for steps and handshakes, check stall stability,
  // play the checker's verdict and optionally randomise req_ready.
  task automatic tick();
    bit hs, stall, rst_pre;
    logic [1:0]    c;
    logic [AW-1:0] s;
    rst_pre = reset;
    hs      = !reset && req_valid && req_ready;
    stall   = !reset && req_valid && !req_ready;
    c       = req_core;
    s       = req_steps;
    if (!reset && !done)
      for (int i = 0; i < NC; i++) inj[i] += 64'(step_in[i*SW +: SW]);
    @(posedge clock); #1;
    if (!rst_pre) ticks++;
    if (hs) begin
      n_tests++;
      if (s == 0 || 64'(s) > inj[c] - acc_tot[c]) begin
        n_fail++;
        $display("FAIL req_steps_bound: core %0d got %0d, required 1..%0d", c, s, inj[c] - acc_tot[c]);
      end
      acc_tot[c] += 64'(s);
      seen_q.push_back(c);
      awaiting = 1'b1;
      rsp_wait = rsp_delay;
    end
    if (stall && !done) begin
      n_tests++;
      if (req_valid !== 1'b1 || req_core !== c || req_steps !== s) begin
        n_fail++;
        $display("FAIL stall_stable: got v=%0b core=%0d steps=%0d, required v=1 core=%0d steps=%0d",
                 req_valid, req_core, req_steps, c, s);
      end
    end
    rsp_valid = 1'b0;
    rsp_trap  = 32'd0;
    if (awaiting && auto_rsp) begin
      if (rsp_wait == 0) begin
        rsp_valid = 1'b1;
        rsp_trap  = trap_cfg;
        awaiting  = 1'b0;
      end else begin
        rsp_wait--;
      end
    end
    if (rand_ready) req_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset = 1'b1; step_in = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_trap = '0;
    max_cycles = '0; max_instrs = '0; auto_rsp = 1'b1; awaiting = 1'b0;
    rsp_delay = 0; rsp_wait = 0; rand_ready = 1'b0; trap_cfg = '0;
    repeat (3) tick();
    for (int i = 0; i < NC; i++) begin inj[i] = 0; acc_tot[i] = 0; end
    ticks = 0;
    seen_q.delete();
    exp_q.delete();
    reset = 1'b0;
  endtask

  // Stop stepping, let the checker drain everything, check conservation.
  task automatic drain(input string name);
    int budget = 200;
    step_in = '0; rand_ready = 1'b0; req_ready = 1'b1;
    repeat (3) tick();
    while (n_instrs != inj_sum() && budget > 0) begin tick(); budget--; end
    n_tests++;
    if (n_instrs !== inj_sum()) begin
      n_fail++;
      $display("FAIL %s_conserve: n_instrs %0d, required %0d", name, n_instrs, inj_sum());
    end
    for (int i = 0; i < NC; i++) begin
      n_tests++;
      if (acc_tot[i] != inj[i]) begin
        n_fail++;
        $display("FAIL %s_core%0d: accepted %0d, required %0d", name, i, acc_tot[i], inj[i]);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    while (!done && budget > 0) begin tick(); budget--; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    tick();
    n_tests++;
    if ({init_valid, req_valid, done, done_cause, req_core, req_steps} !== '0 ||
        n_cycles !== 64'd0 || n_instrs !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: iv=%0b rv=%0b d=%0b dc=%0d core=%0d steps=%0d cyc=%0d ins=%0d, required all 0",
               init_valid, req_valid, done, done_cause, req_core, req_steps, n_cycles, n_instrs);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (init_valid !== 1'b1) begin n_fail++; $display("FAIL init_pulse: got %0b, required 1", init_valid); end
    tick();
    n_tests++;
    if (init_valid !== 1'b0) begin n_fail++; $display("FAIL init_once: got %0b, required 0", init_valid); end
  endtask

  task automatic test_single_core();
    do_reset();
    tick();
    step_in[0 +: SW] = 8'd3;
    tick();
    step_in = '0;
    n_tests++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL sc_early1: req_valid %0b, required 0", req_valid); end
    tick();
    n_tests++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL sc_early2: req_valid %0b, required 0", req_valid); end
    tick();
    n_tests++;
    if (req_valid !== 1'b1 || req_steps !== 16'd3 || req_core !== 2'd0) begin
      n_fail++;
      $display("FAIL sc_req: v=%0b steps=%0d core=%0d, required v=1 steps=3 core=0", req_valid, req_steps, req_core);
    end
    req_ready = 1'b1;
    tick();
    n_tests++;
    if (req_valid !== 1'b0 || n_instrs !== 64'd3) begin
      n_fail++;
      $display("FAIL sc_handshake: v=%0b n_instrs=%0d, required v=0 n_instrs=3", req_valid, n_instrs);
    end
    repeat (5) tick();
    n_tests++;
    if (n_instrs !== 64'd3 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_settle: n_instrs=%0d done=%0b, required 3 and 0", n_instrs, done);
    end
  endtask

  task automatic test_round_robin();
    int budget = 60;
    do_reset();
    req_ready = 1'b1;
    for (int i = 0; i < NC; i++) step_in[i*SW +: SW] = 8'd1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
      while (seen_q.size() > 0 && exp_q.size() > 0) begin
        logic [1:0] got, want;
        got  = seen_q.pop_front();
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL rr_order: core %0d, required %0d", got, want); end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_timeout: %0d grants outstanding, required 0", exp_q.size());
    end
    drain("rr");
  endtask

  task automatic test_stall();
    int budget = 10;
    do_reset();
    step_in[2*SW +: SW] = 8'd5;
    tick();
    step_in = '0;
    while (!req_valid && budget > 0) begin tick(); budget--; end
    n_tests++;
    if (req_valid !== 1'b1 || req_core !== 2'd2 || req_steps !== 16'd5) begin
      n_fail++;
      $display("FAIL stall_req: v=%0b core=%0d steps=%0d, required v=1 core=2 steps=5", req_valid, req_core, req_steps);
    end
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NC; i++) step_in[i*SW +: SW] = 8'($urandom_range(0, 7));
      tick();
    end
    drain("stall");
  endtask

  task automatic test_verdict(input string name, input logic [31:0] trap,
                              input logic [63:0] mi, input logic [2:0] want);
    do_reset();
    max_instrs = mi;
    trap_cfg   = trap;
    req_ready  = 1'b1;
    step_in[0 +: SW] = 8'd2;
    tick();
    step_in = '0;
    wait_done(30);
    n_tests++;
    if (done !== 1'b1 || done_cause !== want || n_instrs !== 64'd2) begin
      n_fail++;
      $display("FAIL %s: done=%0b cause=%0d n_instrs=%0d, required 1, %0d, 2", name, done, done_cause, n_instrs, want);
    end
    for (int i = 0; i < NC; i++) step_in[i*SW +: SW] = 8'd1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (req_valid !== 1'b0 || done !== 1'b1 || done_cause !== want) begin
        n_fail++;
        $display("FAIL %s_sticky: v=%0b done=%0b cause=%0d, required 0, 1, %0d", name, req_valid, done, done_cause, want);
      end
    end
  endtask

  task automatic test_max_cycles();
    do_reset();
    max_cycles = 64'd50;
    wait_done(200);
`ifdef DIFFTEST_STEP_TIMEOUT_EN
    n_tests++;
    if (done !== 1'b1 || done_cause !== 3'd4) begin
      n_fail++;
      $display("FAIL watchdog: done=%0b cause=%0d, required 1 and 4", done, done_cause);
    end
`else
    n_tests++;
    if (done !== 1'b1 || done_cause !== 3'd5 || n_cycles !== 64'd50) begin
      n_fail++;
      $display("FAIL max_cycles: done=%0b cause=%0d n_cycles=%0d, required 1, 5, 50", done, done_cause, n_cycles);
    end
`endif
  endtask

  task automatic test_overflow();
    do_reset();
    step_in[1*SW +: SW] = 8'd255;
    repeat (257) tick();
    step_in = '0;
    repeat (5) tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_at_max: done=%0b cause=%0d, required done 0", done, done_cause);
    end
    step_in[1*SW +: SW] = 8'd1;
    tick();
    step_in = '0;
    wait_done(6);
    n_tests++;
    if (done !== 1'b1 || done_cause !== 3'd3) begin
      n_fail++;
      $display("FAIL ovf_cause: done=%0b cause=%0d, required 1 and 3", done, done_cause);
    end
  endtask

  task automatic test_reset_mid();
    int budget = 10;
    do_reset();
    step_in[3*SW +: SW] = 8'd4;
    tick();
    step_in = '0;
    while (!req_valid && budget > 0) begin tick(); budget--; end
    reset = 1'b1;
    tick();
    n_tests++;
    if (req_valid !== 1'b0 || n_instrs !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%0b n_instrs=%0d, required 0 and 0", req_valid, n_instrs);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    rand_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NC; i++)
        step_in[i*SW +: SW] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
      rsp_delay = $urandom_range(0, 3);
      tick();
    end
    n_tests++;
    if (n_cycles !== 64'(ticks - 1) || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_cycles: n_cycles=%0d done=%0b, required %0d and 0", n_cycles, done, ticks - 1);
    end
    drain("rand");
  endtask

  initial begin
    test_reset();
    test_single_core();
    test_round_robin();
    test_stall();
    test_verdict("fail_verdict", 32'h1, 64'd0, 3'd1);
    test_verdict("checkpoint", 32'hff, 64'd100, 3'd2);
    test_verdict("ckpt_disabled", 32'hff, 64'd0, 3'd1);
    test_max_cycles();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
